// File: rtl/tuner_phy_pkg.sv
// Shared types for the ring tuner control path.
// tuner_ctrl_state_e is the controller state encoding, also exported on o_state.
package tuner_phy_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SRCH_TRIG = 3'd1,
        SRCH_WAIT = 3'd2,
        SELECT    = 3'd3,
        LOCK_TRIG = 3'd4,
        TRACK     = 3'd5,
        ERR       = 3'd6
    } tuner_ctrl_state_e;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tuner_peak_select.sv
// Peak selector for the tuner controller.
// Mode 0 scans one table entry per cycle and keeps the strongest (strict >, so ties
// keep the lowest index); mode 1 returns the requested index in a single cycle.
// Entries at or above the captured count are never examined.
module tuner_peak_select
    import tuner_phy_pkg::*;
#(
    parameter int unsigned ADC_WIDTH  = 8,
    parameter int unsigned NUM_TARGET = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_clr,
    input  logic                              i_en,
    input  logic                              i_mode,
    input  logic [$clog2(NUM_TARGET)-1:0]     i_idx,
    input  logic [$clog2(NUM_TARGET):0]       i_cnt,
    input  logic [ADC_WIDTH*NUM_TARGET-1:0]   i_pwr_tbl,
    output logic [$clog2(NUM_TARGET)-1:0]     o_sel_idx,
    output logic                              o_done,
    output logic                              o_err
);

    localparam int unsigned IW = idx_width(NUM_TARGET);
    localparam int unsigned CW = IW + 1;

    logic [ADC_WIDTH-1:0] w_pwr [NUM_TARGET];
    logic [IW-1:0]        r_scan;
    logic [IW-1:0]        r_best_idx;
    logic [ADC_WIDTH-1:0] r_best_pwr;
    logic [ADC_WIDTH-1:0] w_cur_pwr;
    logic                 w_bad;
    logic                 w_last;
    logic                 w_take;

    for (genvar g = 0; g < NUM_TARGET; g++) begin : g_unpack
        assign w_pwr[g] = i_pwr_tbl[g*ADC_WIDTH +: ADC_WIDTH];
    end

    // Candidate evaluation for the entry under the scan pointer.
    always_comb begin
        w_cur_pwr = w_pwr[r_scan];
        w_bad     = (i_cnt == '0) || (i_mode && ({1'b0, i_idx} >= i_cnt));
        // Stop at the last counted entry, or at the table end if count overshoots.
        w_last    = ({1'b0, r_scan} == (i_cnt - CW'(1))) || (r_scan == IW'(NUM_TARGET - 1));
        w_take    = (r_scan == '0) || (w_cur_pwr > r_best_pwr);
        o_sel_idx = i_mode ? i_idx : (w_take ? r_scan : r_best_idx);
        o_done    = i_en && !w_bad && (i_mode || w_last);
        o_err     = i_en && w_bad;
    end

    // Scan pointer and running maximum; cleared on every new table capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scan     <= '0;
            r_best_idx <= '0;
            r_best_pwr <= '0;
        end else if (i_clr) begin
            r_scan     <= '0;
            r_best_idx <= '0;
            r_best_pwr <= '0;
        end else if (i_en && !i_mode && !w_bad) begin
            if (!w_last) begin
                r_scan <= r_scan + IW'(1);
            end
            if (w_take) begin
                r_best_idx <= r_scan;
                r_best_pwr <= w_cur_pwr;
            end
        end
    end

endmodule

// File: rtl/tuner_ctrl.sv
// Ring tuner controller: search -> peak select -> lock -> track sequencing.
// Optional feature macro TUNER_CTRL_RETRY_EN: when defined, lock loss re-runs the
// search up to MAX_RETRY times before erroring; otherwise lock loss errors at once.
module tuner_ctrl
    import tuner_phy_pkg::*;
#(
    parameter int unsigned DAC_WIDTH  = 8,
    parameter int unsigned ADC_WIDTH  = 8,
    parameter int unsigned NUM_TARGET = 8,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic                              i_abort,
    output logic                              o_search_trig_val,
    input  logic                              i_search_trig_rdy,
    input  logic                              i_peaks_val,
    output logic                              o_peaks_rdy,
    input  logic [DAC_WIDTH*NUM_TARGET-1:0]   i_ring_tune_peaks,
    input  logic [ADC_WIDTH*NUM_TARGET-1:0]   i_pwr_peaks,
    input  logic [$clog2(NUM_TARGET):0]       i_peaks_cnt,
    input  logic                              i_cfg_sel_mode,
    input  logic [$clog2(NUM_TARGET)-1:0]     i_cfg_peak_idx,
    output logic [ADC_WIDTH-1:0]              o_cfg_pwr_peak,
    output logic [DAC_WIDTH-1:0]              o_cfg_ring_tune_peak,
    output logic                              o_lock_trig_val,
    input  logic                              i_lock_trig_rdy,
    output logic                              o_lock_track_rdy,
    input  logic                              i_lock_err,
    output tuner_ctrl_state_e                 o_state,
    output logic                              o_err
);

    localparam int unsigned IW = idx_width(NUM_TARGET);
    localparam int unsigned CW = IW + 1;

    tuner_ctrl_state_e r_state;
    tuner_ctrl_state_e w_state_d;

    logic [ADC_WIDTH*NUM_TARGET-1:0] r_pwr_tbl;
    logic [DAC_WIDTH*NUM_TARGET-1:0] r_tune_tbl;
    logic [CW-1:0]                   r_cnt;
    logic                            r_mode;
    logic [IW-1:0]                   r_idx;

    logic [ADC_WIDTH-1:0] w_pwr_arr  [NUM_TARGET];
    logic [DAC_WIDTH-1:0] w_tune_arr [NUM_TARGET];

    logic [ADC_WIDTH-1:0] r_cfg_pwr;
    logic [DAC_WIDTH-1:0] r_cfg_tune;
    logic                 r_search_trig_val;
    logic                 r_peaks_rdy;
    logic                 r_lock_trig_val;
    logic                 r_lock_track_rdy;
    logic                 r_err;

    logic          w_capture;
    logic          w_sel_en;
    logic [IW-1:0] w_sel_idx;
    logic          w_sel_done;
    logic          w_sel_err;
    logic          w_cfg_load;

`ifdef TUNER_CTRL_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] r_retry;
    logic [RW-1:0] w_retry_d;
`endif

    for (genvar g = 0; g < NUM_TARGET; g++) begin : g_unpack
        assign w_pwr_arr[g]  = r_pwr_tbl[g*ADC_WIDTH +: ADC_WIDTH];
        assign w_tune_arr[g] = r_tune_tbl[g*DAC_WIDTH +: DAC_WIDTH];
    end

    assign w_capture  = (r_state == SRCH_WAIT) && i_peaks_val && r_peaks_rdy && !i_abort;
    assign w_sel_en   = (r_state == SELECT);
    assign w_cfg_load = w_sel_done && !i_abort;

    tuner_peak_select #(
        .ADC_WIDTH  (ADC_WIDTH),
        .NUM_TARGET (NUM_TARGET)
    ) u_peak_select (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_capture),
        .i_en      (w_sel_en),
        .i_mode    (r_mode),
        .i_idx     (r_idx),
        .i_cnt     (r_cnt),
        .i_pwr_tbl (r_pwr_tbl),
        .o_sel_idx (w_sel_idx),
        .o_done    (w_sel_done),
        .o_err     (w_sel_err)
    );

    // Next-state decode; abort overrides every transition.
    always_comb begin
        w_state_d = r_state;
`ifdef TUNER_CTRL_RETRY_EN
        w_retry_d = r_retry;
`endif
        if (i_abort) begin
            w_state_d = IDLE;
`ifdef TUNER_CTRL_RETRY_EN
            w_retry_d = '0;
`endif
        end else begin
            unique case (r_state)
                IDLE:      if (i_start) w_state_d = SRCH_TRIG;
                SRCH_TRIG: if (i_search_trig_rdy) w_state_d = SRCH_WAIT;
                SRCH_WAIT: if (i_peaks_val) w_state_d = SELECT;
                SELECT: begin
                    if (w_sel_err) begin
                        w_state_d = ERR;
                    end else if (w_sel_done) begin
                        w_state_d = LOCK_TRIG;
                    end
                end
                LOCK_TRIG: if (i_lock_trig_rdy) w_state_d = TRACK;
                TRACK: begin
                    if (i_lock_err) begin
`ifdef TUNER_CTRL_RETRY_EN
                        if (32'(r_retry) < MAX_RETRY) begin
                            w_retry_d = r_retry + RW'(1);
                            w_state_d = SRCH_TRIG;
                        end else begin
                            w_state_d = ERR;
                        end
`else
                        w_state_d = ERR;
`endif
                    end
                end
                ERR:       w_state_d = ERR;
                default:   w_state_d = IDLE;
            endcase
        end
    end

    // State register plus handshake/error flags registered from the next state,
    // so each flag is high exactly while its owning state is current.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state           <= IDLE;
            r_search_trig_val <= 1'b0;
            r_peaks_rdy       <= 1'b0;
            r_lock_trig_val   <= 1'b0;
            r_lock_track_rdy  <= 1'b0;
            r_err             <= 1'b0;
        end else begin
            r_state           <= w_state_d;
            r_search_trig_val <= (w_state_d == SRCH_TRIG);
            r_peaks_rdy       <= (w_state_d == SRCH_WAIT);
            r_lock_trig_val   <= (w_state_d == LOCK_TRIG);
            r_lock_track_rdy  <= (w_state_d == TRACK);
            r_err             <= (w_state_d == ERR);
        end
    end

    // Peak table capture on the search-result handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwr_tbl  <= '0;
            r_tune_tbl <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_idx      <= '0;
        end else if (w_capture) begin
            r_pwr_tbl  <= i_pwr_peaks;
            r_tune_tbl <= i_ring_tune_peaks;
            r_cnt      <= i_peaks_cnt;
            r_mode     <= i_cfg_sel_mode;
            r_idx      <= i_cfg_peak_idx;
        end
    end

    // Selected peak handed to the lock stage; held until the next successful select.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cfg_pwr  <= '0;
            r_cfg_tune <= '0;
        end else if (w_cfg_load) begin
            r_cfg_pwr  <= w_pwr_arr[w_sel_idx];
            r_cfg_tune <= w_tune_arr[w_sel_idx];
        end
    end

`ifdef TUNER_CTRL_RETRY_EN
    // Lock-loss retry count; only abort or reset clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_retry <= '0;
        end else begin
            r_retry <= w_retry_d;
        end
    end
`endif

    assign o_search_trig_val    = r_search_trig_val;
    assign o_peaks_rdy          = r_peaks_rdy;
    assign o_lock_trig_val      = r_lock_trig_val;
    assign o_lock_track_rdy     = r_lock_track_rdy;
    assign o_err                = r_err;
    assign o_cfg_pwr_peak       = r_cfg_pwr;
    assign o_cfg_ring_tune_peak = r_cfg_tune;
    assign o_state              = r_state;

endmodule

// File: tb/tb_tuner_ctrl.sv
// Directed self-checking bench for tuner_ctrl with a scoreboard of expected selections.
module tb_tuner_ctrl;
    import tuner_phy_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NT = 8;
    localparam int IW = 3;
    localparam int CW = 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic              i_abort;
    logic              o_search_trig_val;
    logic              i_search_trig_rdy;
    logic              i_peaks_val;
    logic              o_peaks_rdy;
    logic [DW*NT-1:0]  i_ring_tune_peaks;
    logic [AW*NT-1:0]  i_pwr_peaks;
    logic [CW-1:0]     i_peaks_cnt;
    logic              i_cfg_sel_mode;
    logic [IW-1:0]     i_cfg_peak_idx;
    logic [AW-1:0]     o_cfg_pwr_peak;
    logic [DW-1:0]     o_cfg_ring_tune_peak;
    logic              o_lock_trig_val;
    logic              i_lock_trig_rdy;
    logic              o_lock_track_rdy;
    logic              i_lock_err;
    tuner_ctrl_state_e o_state;
    logic              o_err;

    tuner_ctrl #(
        .DAC_WIDTH  (DW),
        .ADC_WIDTH  (AW),
        .NUM_TARGET (NT),
        .MAX_RETRY  (3)
    ) dut (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_start              (i_start),
        .i_abort              (i_abort),
        .o_search_trig_val    (o_search_trig_val),
        .i_search_trig_rdy    (i_search_trig_rdy),
        .i_peaks_val          (i_peaks_val),
        .o_peaks_rdy          (o_peaks_rdy),
        .i_ring_tune_peaks    (i_ring_tune_peaks),
        .i_pwr_peaks          (i_pwr_peaks),
        .i_peaks_cnt          (i_peaks_cnt),
        .i_cfg_sel_mode       (i_cfg_sel_mode),
        .i_cfg_peak_idx       (i_cfg_peak_idx),
        .o_cfg_pwr_peak       (o_cfg_pwr_peak),
        .o_cfg_ring_tune_peak (o_cfg_ring_tune_peak),
        .o_lock_trig_val      (o_lock_trig_val),
        .i_lock_trig_rdy      (i_lock_trig_rdy),
        .o_lock_track_rdy     (o_lock_track_rdy),
        .i_lock_err           (i_lock_err),
        .o_state              (o_state),
        .o_err                (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit         err;
        int         lat;
        logic [7:0] pwr;
        logic [7:0] tune;
    } exp_t;

    exp_t sb[$];
    int   m_pwr  [NT];
    int   m_tune [NT];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference selection: strongest peak with lowest index on ties, or indexed peak.
    function automatic exp_t ref_model(input int cnt, input bit mode, input int idx);
        exp_t e;
        int   best;
        e.err = 1'b0; e.lat = 0; e.pwr = '0; e.tune = '0;
        if (cnt == 0 || (mode && idx >= cnt)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        if (mode) begin
            best  = idx;
            e.lat = 1;
        end else begin
            best = 0;
            for (int i = 1; i < cnt; i++) begin
                if (m_pwr[i] > m_pwr[best]) best = i;
            end
            e.lat = cnt;
        end
        e.pwr  = 8'(m_pwr[best]);
        e.tune = 8'(m_tune[best]);
        return e;
    endfunction

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic pulse_abort();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
    endtask

    // From SRCH_TRIG: hold ready low for 'delay' cycles, then do one transfer.
    task automatic search_phase(input int delay);
        check("srch_trig_state", o_state, SRCH_TRIG);
        for (int i = 0; i < delay; i++) begin
            check("srch_val_hold", o_search_trig_val, 1);
            tick();
        end
        check("srch_trig_still", o_state, SRCH_TRIG);
        i_search_trig_rdy = 1'b1;
        tick();
        i_search_trig_rdy = 1'b0;
        check("srch_wait_state", o_state, SRCH_WAIT);
        check("srch_val_drop", o_search_trig_val, 0);
        check("peaks_rdy_high", o_peaks_rdy, 1);
    endtask

    // From SRCH_WAIT: present the model tables, then follow select and lock.
    task automatic select_phase(input int cnt, input bit mode, input int idx);
        exp_t e;
        int   n;
        for (int i = 0; i < NT; i++) begin
            i_pwr_peaks[i*AW +: AW]       = 8'(m_pwr[i]);
            i_ring_tune_peaks[i*DW +: DW] = 8'(m_tune[i]);
        end
        i_peaks_cnt    = CW'(cnt);
        i_cfg_sel_mode = mode;
        i_cfg_peak_idx = IW'(idx);
        i_peaks_val    = 1'b1;
        sb.push_back(ref_model(cnt, mode, idx));
        tick();
        i_peaks_val = 1'b0;
        // Scramble live inputs: the DUT must work from its captured copy.
        i_pwr_peaks       = {$urandom, $urandom};
        i_ring_tune_peaks = {$urandom, $urandom};
        i_cfg_peak_idx    = IW'($urandom_range(0, 7));
        check("select_state", o_state, SELECT);
        check("peaks_rdy_drop", o_peaks_rdy, 0);
        n = 0;
        while (o_state == SELECT && n < 20) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        check("select_latency", n, e.lat);
        if (e.err) begin
            check("err_state", o_state, ERR);
            check("err_flag", o_err, 1);
            check("err_no_lock", o_lock_trig_val, 0);
        end else begin
            check("lock_trig_state", o_state, LOCK_TRIG);
            check("lock_trig_val", o_lock_trig_val, 1);
            check("cfg_pwr", o_cfg_pwr_peak, e.pwr);
            check("cfg_tune", o_cfg_ring_tune_peak, e.tune);
            tick();
            check("lock_val_hold", o_lock_trig_val, 1);
            i_lock_trig_rdy = 1'b1;
            tick();
            i_lock_trig_rdy = 1'b0;
            check("track_state", o_state, TRACK);
            check("track_rdy", o_lock_track_rdy, 1);
            check("lock_val_drop", o_lock_trig_val, 0);
        end
    endtask

    task automatic load_table_a();
        m_pwr  = '{10, 40, 40, 5, 255, 255, 255, 255};
        m_tune = '{100, 101, 102, 103, 104, 105, 106, 107};
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_search_trig_rdy = 1'b0; i_peaks_val = 1'b0; i_peaks_cnt = '0;
        i_pwr_peaks = '0; i_ring_tune_peaks = '0;
        i_cfg_sel_mode = 1'b0; i_cfg_peak_idx = '0;
        i_lock_trig_rdy = 1'b0; i_lock_err = 1'b0;
        #12;
        check("rst_state", o_state, IDLE);
        check("rst_srch_val", o_search_trig_val, 0);
        check("rst_peaks_rdy", o_peaks_rdy, 0);
        check("rst_lock_val", o_lock_trig_val, 0);
        check("rst_track_rdy", o_lock_track_rdy, 0);
        check("rst_err", o_err, 0);
        check("rst_cfg_pwr", o_cfg_pwr_peak, 0);
        check("rst_cfg_tune", o_cfg_ring_tune_peak, 0);
        tick();
        i_rst = 1'b0;
        tick();
        check("idle_after_rst", o_state, IDLE);

        // Mode 0 argmax with a tie; entries beyond count are loud but ignored.
        load_table_a();
        pulse_start();
        search_phase(0);
        select_phase(4, 1'b0, 0);
        check("tie_pwr_40", o_cfg_pwr_peak, 40);
        check("tie_tune_idx1", o_cfg_ring_tune_peak, 101);
        pulse_start();
        check("start_ignored_track", o_state, TRACK);
        pulse_abort();
        check("abort_idle", o_state, IDLE);
        check("abort_track_rdy", o_lock_track_rdy, 0);
        check("abort_cfg_held", o_cfg_pwr_peak, 40);

        // Mode 1 indexed select with a delayed search handshake.
        m_pwr  = '{7, 3, 9, 1, 6, 2, 8, 4};
        m_tune = '{20, 21, 22, 23, 24, 25, 26, 27};
        pulse_start();
        search_phase(2);
        select_phase(5, 1'b1, 2);
        pulse_abort();

        // Index out of range in mode 1 -> error, start ignored, abort recovers.
        pulse_start();
        search_phase(0);
        select_phase(3, 1'b1, 3);
        i_start = 1'b1;
        repeat (3) tick();
        i_start = 1'b0;
        check("err_sticky", o_state, ERR);
        check("err_flag_sticky", o_err, 1);
        check("err_cfg_held", o_cfg_pwr_peak, 9);
        pulse_abort();
        check("err_abort_idle", o_state, IDLE);
        check("err_abort_clr", o_err, 0);

        // Zero peaks -> error, lock trigger never raised.
        pulse_start();
        search_phase(0);
        select_phase(0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cnt0_no_lock", o_lock_trig_val, 0);
        end
        pulse_abort();

        // Five-cycle search back-pressure, then a full-table random scan.
        for (int i = 0; i < NT; i++) begin
            m_pwr[i]  = $urandom_range(0, 255);
            m_tune[i] = $urandom_range(0, 255);
        end
        m_pwr[6] = m_pwr[3];
        pulse_start();
        search_phase(5);
        select_phase(8, 1'b0, 0);
        pulse_abort();

        // Abort wins over a simultaneous search handshake.
        pulse_start();
        i_search_trig_rdy = 1'b1;
        pulse_abort();
        i_search_trig_rdy = 1'b0;
        check("abort_prio_idle", o_state, IDLE);
        check("abort_prio_val", o_search_trig_val, 0);

        // Lock loss handling.
        load_table_a();
        pulse_start();
        search_phase(0);
        select_phase(4, 1'b0, 0);
`ifdef TUNER_CTRL_RETRY_EN
        for (int k = 0; k < 3; k++) begin
            i_lock_err = 1'b1;
            tick();
            i_lock_err = 1'b0;
            check("retry_research", o_state, SRCH_TRIG);
            search_phase(1);
            select_phase(4, 1'b0, 0);
        end
        i_lock_err = 1'b1;
        tick();
        i_lock_err = 1'b0;
        check("retry_exhausted", o_state, ERR);
        check("retry_err_flag", o_err, 1);
        pulse_abort();
        // Abort must have cleared the retry count.
        pulse_start();
        search_phase(0);
        select_phase(4, 1'b0, 0);
        i_lock_err = 1'b1;
        tick();
        i_lock_err = 1'b0;
        check("retry_cleared", o_state, SRCH_TRIG);
`else
        i_lock_err = 1'b1;
        tick();
        i_lock_err = 1'b0;
        check("lockerr_to_err", o_state, ERR);
        check("lockerr_flag", o_err, 1);
`endif
        pulse_abort();

        // Asynchronous reset in the middle of a scan.
        pulse_start();
        search_phase(0);
        for (int i = 0; i < NT; i++) begin
            i_pwr_peaks[i*AW +: AW]       = 8'(m_pwr[i]);
            i_ring_tune_peaks[i*DW +: DW] = 8'(m_tune[i]);
        end
        i_peaks_cnt    = CW'(8);
        i_cfg_sel_mode = 1'b0;
        i_peaks_val    = 1'b1;
        tick();
        i_peaks_val = 1'b0;
        tick();
        check("mid_select", o_state, SELECT);
        #2 i_rst = 1'b1;
        #1;
        check("async_rst_state", o_state, IDLE);
        check("async_rst_cfg_pwr", o_cfg_pwr_peak, 0);
        check("async_rst_cfg_tune", o_cfg_ring_tune_peak, 0);
        check("async_rst_vals", {o_search_trig_val, o_peaks_rdy, o_lock_trig_val,
                                 o_lock_track_rdy, o_err}, 0);
        tick();
        i_rst = 1'b0;
        tick();
        check("post_rst_idle", o_state, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
